// File: rtl/fifo_write_arbiter_if.sv
// Bundle of the requester-side and FIFO-side signals of the write arbiter.
// The master modport is the arbiter. The slave modport is the requesters and the FIFO.
interface fifo_write_arbiter_if #(
    parameter int unsigned DW = 32
);
    logic [3:0]      req;
    logic [4*DW-1:0] wdata;
    logic [3:0]      ack;
    logic [3:0]      gnt;
    logic            FULL;
    logic            WR;
    logic            EN;
    logic [DW-1:0]   dataIn;
    logic [15:0]     wr_count;

    modport master (
        input  req, wdata, FULL,
        output ack, gnt, WR, EN, dataIn, wr_count
    );

    modport slave (
        output req, wdata, FULL,
        input  ack, gnt, WR, EN, dataIn, wr_count
    );
endinterface

// File: rtl/fifo_write_arbiter.sv
// Round-robin arbiter that lets four requesters write bursts of up to BURST words into one FIFO.
// Every grant is followed by one idle arbitration cycle.
module fifo_write_arbiter #(
    parameter int unsigned DW    = 32,
    parameter int unsigned BURST = 4
) (
    input logic                 Clk,
    input logic                 Rst,
    fifo_write_arbiter_if.master bus
);

    typedef enum logic {StIdle, StXfer} state_e;

    state_e      r_state, w_state_nxt;
    logic [3:0]  r_gnt, w_gnt_nxt;
    logic [1:0]  r_last, w_last_nxt;
    logic [3:0]  r_beat, w_beat_nxt;
    logic [15:0] r_wr_count;
    logic        r_en;

    logic [1:0]    w_g;
    logic [1:0]    w_pick;
    logic          w_req_g;
    logic          w_accept;
    logic          w_last_beat;
    logic [DW-1:0] w_data_mux;

    always_comb begin
        w_g = 2'd0;
        for (int i = 0; i < 4; i++) begin
            if (r_gnt[i]) w_g = 2'(i);
        end
    end

    assign w_req_g     = bus.req[w_g];
    // Rst gating keeps WR/ack low during reset even while a grant is still registered.
    assign w_accept    = (r_state == StXfer) && w_req_g && !bus.FULL && !Rst;
    assign w_last_beat = (r_beat == 4'(BURST - 1));

    // Search starts one past the previous grantee and wraps, so everyone gets a turn.
    always_comb begin : p_pick
        logic       found;
        logic [1:0] idx;
        found  = 1'b0;
        idx    = r_last;
        w_pick = r_last;
        for (int k = 1; k <= 4; k++) begin
            idx = r_last + 2'(k);
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                w_pick = idx;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_last_nxt  = r_last;
        w_beat_nxt  = r_beat;
        case (r_state)
            StIdle: begin
                if (bus.req != 4'b0000) begin
                    w_state_nxt = StXfer;
                    w_gnt_nxt   = 4'b0001 << w_pick;
                end
            end
            StXfer: begin
                if (!w_req_g || (w_accept && w_last_beat)) begin
                    w_state_nxt = StIdle;
                    w_gnt_nxt   = 4'b0000;
                    w_last_nxt  = w_g;
                    w_beat_nxt  = 4'd0;
                end else if (w_accept) begin
                    w_beat_nxt = r_beat + 4'd1;
                end
            end
            default: begin
                w_state_nxt = StIdle;
                w_gnt_nxt   = 4'b0000;
            end
        endcase
    end

    always_ff @(posedge Clk) begin
        if (Rst) begin
            r_state    <= StIdle;
            r_gnt      <= 4'b0000;
            r_last     <= 2'd3;
            r_beat     <= 4'd0;
            r_wr_count <= 16'd0;
            r_en       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_gnt   <= w_gnt_nxt;
            r_last  <= w_last_nxt;
            r_beat  <= w_beat_nxt;
            r_en    <= 1'b1;
            if (w_accept) r_wr_count <= r_wr_count + 16'd1;
        end
    end

    always_comb begin
        w_data_mux = '0;
        if (!Rst && (r_gnt != 4'b0000)) w_data_mux = bus.wdata[32'(w_g) * DW +: DW];
    end

    assign bus.WR       = w_accept;
    assign bus.ack      = w_accept ? r_gnt : 4'b0000;
    assign bus.gnt      = r_gnt;
    assign bus.EN       = r_en;
    assign bus.dataIn   = w_data_mux;
    assign bus.wr_count = r_wr_count;

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// Bench for fifo_write_arbiter. Every expected FIFO word goes into a scoreboard queue when
// its burst is set up. The queue is drained on each WR.
module tb_fifo_write_arbiter;

    localparam int unsigned DW    = 32;
    localparam int unsigned BURST = 4;

    logic Clk = 1'b0;
    logic Rst = 1'b1;

    fifo_write_arbiter_if #(.DW(DW)) bus ();

    fifo_write_arbiter #(.DW(DW), .BURST(BURST)) dut (
        .Clk (Clk),
        .Rst (Rst),
        .bus (bus)
    );

    always #5 Clk = ~Clk;

    int unsigned   n_checks = 0;
    int unsigned   n_errors = 0;
    logic [DW-1:0] exp_q[$];
    int unsigned   seq[4]     = '{default: 0};
    int unsigned   exp_seq[4] = '{default: 0};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] word(input int unsigned r, input int unsigned s);
        return {8'(r), 24'(s)};
    endfunction

    task automatic push_burst(input int unsigned r, input int unsigned n);
        for (int i = 0; i < int'(n); i++) begin
            exp_q.push_back(word(r, exp_seq[r]));
            exp_seq[r]++;
        end
    endtask

    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    // Each requester presents its next word once the current one is acked.
    always_comb begin
        for (int i = 0; i < 4; i++) bus.wdata[i*DW +: DW] = word(i, seq[i]);
    end

    always @(negedge Clk) begin
        logic [DW-1:0] e;
        if (bus.WR) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 64'(bus.WR), 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("data", 64'(bus.dataIn), 64'(e));
                check("ack", 64'(bus.ack), 64'(4'b0001 << e[DW-1 -: 8]));
            end
            check("wr_vs_full", 64'(bus.FULL), 64'd0);
            for (int i = 0; i < 4; i++) if (bus.ack[i]) seq[i]++;
        end else begin
            check("ack_idle", 64'(bus.ack), 64'd0);
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bus.req  = 4'b1111;
        bus.FULL = 1'b0;

        // Reset with all four requesting, then continuous rotation.
        step();
        check("rst_gnt", 64'(bus.gnt), 64'd0);
        check("rst_cnt", 64'(bus.wr_count), 64'd0);
        check("rst_en", 64'(bus.EN), 64'd0);
        check("rst_wr", 64'(bus.WR), 64'd0);
        check("rst_ack", 64'(bus.ack), 64'd0);
        check("rst_data", 64'(bus.dataIn), 64'd0);
        for (int b = 0; b < 8; b++) push_burst(b % 4, BURST);
        Rst = 1'b0;
        step();
        check("first_gnt", 64'(bus.gnt), 64'h1);
        check("first_wr", 64'(bus.WR), 64'd1);
        check("first_ack", 64'(bus.ack), 64'h1);
        check("en_on", 64'(bus.EN), 64'd1);
        repeat (3) begin
            step();
            check("burst0_gnt", 64'(bus.gnt), 64'h1);
        end
        step();
        check("bubble_gnt", 64'(bus.gnt), 64'd0);
        check("bubble_wr", 64'(bus.WR), 64'd0);
        step();
        check("second_gnt", 64'(bus.gnt), 64'h2);
        repeat (34) step();
        check("rot_cnt", 64'(bus.wr_count), 64'd32);
        check("rot_gnt", 64'(bus.gnt), 64'd0);
        check("rot_drain", 64'(exp_q.size()), 64'd0);

        // FULL held for cycles 2-5 of a burst.
        push_burst(0, BURST);
        bus.req = 4'b0001;
        step();
        check("stall_gnt0", 64'(bus.gnt), 64'h1);
        step();
        bus.FULL = 1'b1;
        repeat (4) begin
            step();
            check("stall_gnt", 64'(bus.gnt), 64'h1);
            check("stall_wr", 64'(bus.WR), 64'd0);
            check("stall_ack", 64'(bus.ack), 64'd0);
        end
        bus.FULL = 1'b0;
        repeat (3) step();
        check("stall_end_gnt", 64'(bus.gnt), 64'd0);
        check("stall_cnt", 64'(bus.wr_count), 64'd36);
        check("stall_drain", 64'(exp_q.size()), 64'd0);

        // Requester 2 withdraws after two words; requester 3 is pending.
        push_burst(2, 2);
        push_burst(3, BURST);
        bus.req = 4'b1100;
        step();
        check("wd_gnt2", 64'(bus.gnt), 64'h4);
        step();
        step();
        bus.req = 4'b1000;
        step();
        check("wd_idle", 64'(bus.gnt), 64'd0);
        step();
        check("wd_gnt3", 64'(bus.gnt), 64'h8);
        repeat (4) step();
        check("wd_end_gnt", 64'(bus.gnt), 64'd0);
        check("wd_cnt", 64'(bus.wr_count), 64'd42);
        check("wd_drain", 64'(exp_q.size()), 64'd0);

        // Reset pulsed mid-burst with beat at 2.
        push_burst(2, 2);
        bus.req = 4'b0100;
        step();
        check("mid_gnt", 64'(bus.gnt), 64'h4);
        step();
        step();
        Rst     = 1'b1;
        bus.req = 4'b1111;
        #1;
        check("mid_rst_wr", 64'(bus.WR), 64'd0);
        check("mid_rst_ack", 64'(bus.ack), 64'd0);
        check("mid_rst_data", 64'(bus.dataIn), 64'd0);
        step();
        check("mid_rst_gnt", 64'(bus.gnt), 64'd0);
        check("mid_rst_cnt", 64'(bus.wr_count), 64'd0);
        check("mid_rst_en", 64'(bus.EN), 64'd0);
        Rst = 1'b0;
        push_burst(0, 1);
        step();
        check("post_rst_gnt", 64'(bus.gnt), 64'h1);
        step();
        check("post_rst_cnt", 64'(bus.wr_count), 64'd1);
        bus.req = 4'b0000;
        step();
        check("post_rst_idle", 64'(bus.gnt), 64'd0);

        // wr_count wrap from 0xFFFF.
        force dut.r_wr_count = 16'hFFFF;
        #1;
        release dut.r_wr_count;
        #1;
        check("wrap_pre", 64'(bus.wr_count), 64'hFFFF);
        push_burst(1, 1);
        bus.req = 4'b0010;
        step();
        check("wrap_gnt", 64'(bus.gnt), 64'h2);
        step();
        check("wrap_cnt", 64'(bus.wr_count), 64'd0);
        bus.req = 4'b0000;
        step();
        check("wrap_idle", 64'(bus.gnt), 64'd0);

        check("sb_left", 64'(exp_q.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fifo_write_arbiter.md
FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

Interface
REQ-001 The block SHALL have parameter DW, default 32, meaning the data width (matches the FIFO dataIn width).
REQ-002 The block SHALL have parameter BURST, default 4, meaning the maximum words per grant (range 1..15).
REQ-003 The block SHALL have input Clk, 1 bit: the single clock; all state updates on its posedge.
REQ-004 The block SHALL have input Rst, 1 bit: the reset, synchronous and active-high.
REQ-005 The block SHALL have input req, 4 bits: per-requester write request, level, held until that requester's data is accepted or it withdraws.
REQ-006 The block SHALL have input wdata, 4*DW bits: requester i data in bits [i*DW +: DW].
REQ-007 The block SHALL have output ack, 4 bits: one-hot, combinational, word accepted from requester i this cycle.
REQ-008 The block SHALL have output gnt, 4 bits: one-hot or zero, registered, current grantee.
REQ-009 The block SHALL have input FULL, 1 bit: the FIFO full flag.
REQ-010 The block SHALL have output WR, 1 bit: FIFO write strobe, combinational.
REQ-011 The block SHALL have output EN, 1 bit: FIFO enable, registered.
REQ-012 The block SHALL have output dataIn, DW bits: FIFO write data, combinational mux of wdata by gnt; all zeros when gnt==0.
REQ-013 The block SHALL have output wr_count, 16 bits: total words written, registered.

Function
REQ-014 The FSM SHALL have states IDLE and XFER; gnt SHALL be 0 in IDLE and one-hot in XFER.
REQ-015 IDLE with req!=0: next state SHALL be XFER, with gnt set to the first requester with req set, searching from (last+1) mod 4 upward with wrap; last is the 2-bit index of the previous grantee.
REQ-016 IDLE with req==0: the FSM SHALL stay in IDLE.
REQ-017 Accept condition (accept) SHALL be: state==XFER, req[g]==1 and FULL==0, where g is the grantee.
REQ-018 WR SHALL equal accept; ack[g] SHALL equal accept; all other ack bits SHALL be 0.
REQ-019 On each accept, beat (4-bit) SHALL increment and wr_count SHALL increment, wrapping 0xFFFF->0x0000.
REQ-020 XFER exit: when req[g]==0, or accept occurs with beat==BURST-1, the next state SHALL be IDLE, last SHALL become g, and beat SHALL clear to 0.
REQ-021 XFER with req[g]==1 and FULL==1 (stall): the FSM SHALL hold state, gnt and beat, with WR=0 and ack=0; there is no stall timeout.
REQ-022 Latency: a req rising in IDLE at cycle t SHALL give gnt at t+1; the earliest WR SHALL be at t+1 (FULL==0).
REQ-023 Every grant release SHALL pass through IDLE for exactly one cycle (one bubble), including when the same requester is re-granted.
REQ-024 Requests from non-granted requesters SHALL be ignored until the next IDLE arbitration, and their req SHALL NOT be cleared by the block.
REQ-025 WR SHALL never assert when FULL==1, and at most one ack bit SHALL be high in any cycle.
REQ-026 EN SHALL be 1 in every cycle after the first post-reset clock.

Reset
REQ-027 With Rst==1 at a posedge, the block SHALL set state=IDLE, gnt=0, last=3 (so requester 0 wins first), beat=0, wr_count=0 and EN=0, regardless of current state, including mid-burst.
REQ-028 While Rst==1 the block SHALL force WR=0, ack=0 and dataIn=0.
REQ-029 On the first cycle after Rst deasserts, arbitration SHALL proceed normally.

Verification
REQ-030 Reset with req=4'b1111, FULL=0 -> gnt=0001 one cycle later; 4 words written with ack[0] each cycle; gnt=0 for 1 cycle; then gnt=0010.
REQ-031 Rotation with all four requesting continuously for 40 cycles -> grant order 0,1,2,3,0,...; wr_count=32 after 40 cycles; dataIn matches the grantee's wdata on every WR.
REQ-032 FULL=1 for cycles 2-5 of a burst -> WR=0 and ack=0 during that window; gnt and beat held; the burst resumes and still totals BURST words.
REQ-033 Early withdraw: req[2] drops after 2 accepts -> IDLE next cycle; last=2; a pending req[3] is granted next.
REQ-034 Rst pulsed mid-burst (beat=2, gnt=0100) -> next cycle gnt=0, wr_count=0, WR=0; the following arbitration grants the lowest-index requester.
REQ-035 wr_count preloaded near wrap (drive 65535 writes or force) -> the next accept yields 0x0000.
